// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC FIFO write arbiter.
// Holds the FSM encoding, default sizing and the layout of a result word.
package tdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 32;

  localparam int CALIB_DIFF_MSB = 31;
  localparam int CALIB_DIFF_LSB = 16;
  localparam int TIME1_MSB      = 15;
  localparam int TIME1_LSB      = 0;

  typedef struct packed {
    logic [CALIB_DIFF_MSB-CALIB_DIFF_LSB:0] calib_diff;
    logic [TIME1_MSB-TIME1_LSB:0]           time1;
  } result_t;

endpackage

// File: rtl/tdc_rr_picker.sv
// Combinational round-robin search: first set bit of req_i starting at
// ptr_i+1 and wrapping modulo NUM_CH.
module tdc_rr_picker #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [CH_W-1:0]   grant_o,
  output logic              valid_o
);

  int idx;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    // Scan farthest-first so the nearest eligible channel after ptr wins.
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = (int'(ptr_i) + k) % NUM_CH;
      if (req_i[CH_W'(idx)]) begin
        grant_o = CH_W'(idx);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdc_fifo_arbiter.sv
// Round-robin arbiter that lets NUM_CH TDC controllers share one FIFO write
// port, with a done pulse per write and a drop-on-timeout when the FIFO is full.
module tdc_fifo_arbiter
  import tdc_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FULL_TIMEOUT = 1000,
  parameter int CH_W         = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_wr_en,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [DATA_W-1:0]        fifo_din,
  output logic [CH_W-1:0]          fifo_ch,
  output logic [NUM_CH-1:0]        done,
  output logic                     busy,
  output logic [15:0]              drop_cnt
);

  localparam int TMO_W = (FULL_TIMEOUT > 1) ? $clog2(FULL_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FULL_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [15:0]         drop_q, drop_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;

  logic [NUM_CH-1:0]   req_elig;
  logic [CH_W-1:0]     pick_grant;
  logic                pick_valid;
  logic                tmo_hit;

  // The channel just served is masked for one IDLE cycle so a registered
  // wr_en that has not yet dropped is not granted a second time.
  assign req_elig = req_wr_en & ~mask_q;
  assign tmo_hit  = (tmo_q == TMO_LAST);

  tdc_rr_picker #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_picker (
    .req_i   (req_elig),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= CH_W'(NUM_CH - 1);
      ch_q    <= '0;
      din_q   <= '0;
      tmo_q   <= '0;
      drop_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      din_q   <= din_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    din_d   = din_q;
    tmo_d   = tmo_q;
    drop_d  = drop_q;
    mask_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          din_d   = req_data[int'(pick_grant)*DATA_W +: DATA_W];
          ch_d    = pick_grant;
          ptr_d   = pick_grant;
          tmo_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!fifo_full) begin
          state_d = ST_HOLD;
        end else if (tmo_hit) begin
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          state_d = ST_HOLD;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_HOLD: begin
        mask_d  = NUM_CH'(1) << ch_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_wr_en = (state_q == ST_WRITE) && !fifo_full;
    done       = ((state_q == ST_WRITE) && (!fifo_full || tmo_hit))
                 ? (NUM_CH'(1) << ch_q) : '0;
    busy       = (state_q != ST_IDLE);
  end

  assign fifo_din = din_q;
  assign fifo_ch  = ch_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_tdc_fifo_arbiter.sv
// Bench for tdc_fifo_arbiter: directed scenarios plus randomized requesters,
// all outputs compared every cycle against a transaction-level model.
module tb_tdc_fifo_arbiter;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int TO     = 16;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_CH-1:0]        req_wr_en = '0;
  logic [NUM_CH*DATA_W-1:0] req_data = '0;
  logic                     fifo_full = 1'b0;
  logic                     fifo_wr_en;
  logic [DATA_W-1:0]        fifo_din;
  logic [CH_W-1:0]          fifo_ch;
  logic [NUM_CH-1:0]        done;
  logic                     busy;
  logic [15:0]              drop_cnt;

  always #5 clk = ~clk;

  tdc_fifo_arbiter #(
    .NUM_CH       (NUM_CH),
    .DATA_W       (DATA_W),
    .FULL_TIMEOUT (TO),
    .CH_W         (CH_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_wr_en  (req_wr_en),
    .req_data   (req_data),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_ch    (fifo_ch),
    .done       (done),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: "free" (0), "writing" (1), "cooling down" (2).
  int                m_mode, m_cur, m_last, m_wait, m_drops;
  logic [DATA_W-1:0] m_word;
  logic [NUM_CH-1:0] m_excl;
  int                passed [NUM_CH];

  int                pol [NUM_CH];
  bit                random_mode = 1'b0;
  int                full_left = 0;
  int                cyc = 0;
  int                wr_ch_q [$];
  int                wr_cyc_q [$];
  logic [DATA_W-1:0] wr_data_q [$];

  function automatic void model_reset();
    m_mode  = 0;
    m_cur   = 0;
    m_last  = NUM_CH - 1;
    m_wait  = 0;
    m_drops = 0;
    m_word  = '0;
    m_excl  = '0;
    for (int c = 0; c < NUM_CH; c++) passed[c] = 0;
  endfunction

  function automatic logic [NUM_CH-1:0] model_done();
    if (m_mode == 1 && (!fifo_full || m_wait == TO - 1))
      return NUM_CH'(1) << m_cur;
    return '0;
  endfunction

  task automatic model_step();
    logic [NUM_CH-1:0] elig;
    int g;
    for (int c = 0; c < NUM_CH; c++) if (!req_wr_en[c]) passed[c] = 0;
    case (m_mode)
      0: begin
        elig   = req_wr_en & ~m_excl;
        m_excl = '0;
        g      = -1;
        for (int k = 1; k <= NUM_CH; k++)
          if (g < 0 && elig[(m_last + k) % NUM_CH]) g = (m_last + k) % NUM_CH;
        if (g >= 0) begin
          check("fairness", passed[g] < NUM_CH, 1'b1);
          for (int c = 0; c < NUM_CH; c++) if (c != g && req_wr_en[c]) passed[c]++;
          passed[g] = 0;
          m_cur  = g;
          m_last = g;
          m_word = req_data[g*DATA_W +: DATA_W];
          m_wait = 0;
          m_mode = 1;
        end
      end
      1: begin
        if (!fifo_full) m_mode = 2;
        else if (m_wait == TO - 1) begin
          if (m_drops < 65535) m_drops++;
          m_mode = 2;
        end else m_wait++;
      end
      default: begin
        m_excl = NUM_CH'(1) << m_cur;
        m_mode = 0;
      end
    endcase
  endtask

  // Requesters hold until done, then either release or re-request with new data.
  task automatic bfm(input logic [NUM_CH-1:0] ed);
    for (int i = 0; i < NUM_CH; i++) begin
      if (ed[i]) begin
        if (pol[i] == 1 || (random_mode && $urandom_range(0, 1) == 1))
          req_data[i*DATA_W +: DATA_W] = $urandom();
        else
          req_wr_en[i] = 1'b0;
      end else if (random_mode) begin
        if (!req_wr_en[i] && $urandom_range(0, 3) == 0) begin
          req_wr_en[i] = 1'b1;
          req_data[i*DATA_W +: DATA_W] = $urandom();
        end else if (req_wr_en[i] && $urandom_range(0, 63) == 0) begin
          req_wr_en[i] = 1'b0;
        end
      end
    end
    if (random_mode) begin
      if (full_left > 0) begin
        fifo_full = 1'b1;
        full_left--;
      end else if ($urandom_range(0, 9) == 0) begin
        fifo_full = 1'b1;
        full_left = $urandom_range(0, 20);
      end else begin
        fifo_full = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    logic [NUM_CH-1:0] ed;
    ed = '0;
    @(negedge clk);
    if (rst_n) begin
      ed = model_done();
      check("wr_en", fifo_wr_en, m_mode == 1 && !fifo_full);
      check("done", done, ed);
      check("busy", busy, m_mode != 0);
      check("din", fifo_din, m_word);
      check("ch", fifo_ch, m_cur);
      check("drop_cnt", drop_cnt, m_drops);
      if (fifo_wr_en === 1'b1) begin
        wr_ch_q.push_back(int'(fifo_ch));
        wr_cyc_q.push_back(cyc);
        wr_data_q.push_back(fifo_din);
      end
    end
    @(posedge clk);
    cyc++;
    if (rst_n) model_step();
    #1;
    bfm(ed);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int start, k;
    start = wr_ch_q.size();
    k = 0;
    while (wr_ch_q.size() < start + n && k < budget) begin
      cycle();
      k++;
    end
    check("write_timeout", wr_ch_q.size() >= start + n, 1'b1);
  endtask

  task automatic settle();
    for (int i = 0; i < NUM_CH; i++) pol[i] = 0;
    req_wr_en = '0;
    fifo_full = 1'b0;
    repeat (6) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  int base, d0;

  initial begin
    model_reset();
    for (int i = 0; i < NUM_CH; i++) pol[i] = 0;

    // Reset state
    #2;
    check("rst_wr_en", fifo_wr_en, 1'b0);
    check("rst_done", done, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_din", fifo_din, '0);
    check("rst_ch", fifo_ch, '0);
    check("rst_drop", drop_cnt, '0);
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // Single request, latency and busy duration
    req_data[0*DATA_W +: DATA_W] = 32'h1234_0190;
    req_wr_en = 4'b0001;
    check("t1_idle_busy", busy, 1'b0);
    cycle();
    check("t1_wr_en", fifo_wr_en, 1'b1);
    check("t1_din", fifo_din, 32'h1234_0190);
    check("t1_ch", fifo_ch, 0);
    check("t1_done", done, 4'b0001);
    cycle();
    check("t1_done_once", done, 4'b0000);
    check("t1_busy_hold", busy, 1'b1);
    cycle();
    check("t1_busy_fall", busy, 1'b0);
    settle();

    // All four request together, in-order round robin every 3 cycles
    do_reset();
    for (int i = 0; i < NUM_CH; i++) req_data[i*DATA_W +: DATA_W] = 32'hA0 + i;
    req_wr_en = 4'b1111;
    base = wr_ch_q.size();
    wait_writes(4, 40);
    for (int i = 0; i < 4 && base + i < wr_ch_q.size(); i++) begin
      check("t2_order", wr_ch_q[base+i], i);
      check("t2_data", wr_data_q[base+i], 32'hA0 + i);
      if (i > 0) check("t2_spacing", wr_cyc_q[base+i] - wr_cyc_q[base+i-1], 3);
    end
    settle();

    // ch0 re-requests after every done while ch2 holds: alternate 0,2
    pol[0] = 1;
    pol[2] = 1;
    req_data[0*DATA_W +: DATA_W] = 32'h0000_00C0;
    req_data[2*DATA_W +: DATA_W] = 32'h0000_00C2;
    req_wr_en = 4'b0101;
    base = wr_ch_q.size();
    wait_writes(6, 60);
    for (int i = 1; i < 6 && base + i < wr_ch_q.size(); i++) begin
      check("t3_alternate", wr_ch_q[base+i] != wr_ch_q[base+i-1], 1'b1);
      check("t3_chset", wr_ch_q[base+i] == 0 || wr_ch_q[base+i] == 2, 1'b1);
    end
    settle();

    // FIFO full for 10 cycles after a ch1 grant, below the timeout
    d0 = m_drops;
    fifo_full = 1'b1;
    req_data[1*DATA_W +: DATA_W] = 32'h0000_00B1;
    req_wr_en = 4'b0010;
    cycle();
    for (int k = 0; k < 10; k++) begin
      check("t4_no_write", fifo_wr_en, 1'b0);
      cycle();
    end
    fifo_full = 1'b0;
    #1;
    check("t4_write", fifo_wr_en, 1'b1);
    check("t4_done", done, 4'b0010);
    check("t4_din", fifo_din, 32'h0000_00B1);
    cycle();
    check("t4_no_drop", drop_cnt, d0);
    settle();

    // FIFO held full: drop after TO WRITE cycles
    d0 = m_drops;
    fifo_full = 1'b1;
    req_data[2*DATA_W +: DATA_W] = 32'h0000_00D2;
    req_wr_en = 4'b0100;
    cycle();
    for (int k = 0; k < TO - 1; k++) begin
      check("t5_wait_done", done, 4'b0000);
      cycle();
    end
    check("t5_drop_done", done, 4'b0100);
    check("t5_drop_wr_en", fifo_wr_en, 1'b0);
    cycle();
    check("t5_drop_cnt", drop_cnt, d0 + 1);
    settle();

    // Asynchronous reset in the middle of WRITE
    fifo_full = 1'b1;
    req_data[3*DATA_W +: DATA_W] = 32'h0000_00E3;
    req_wr_en = 4'b1000;
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 1'b0);
    check("t6_done", done, '0);
    check("t6_wr_en", fifo_wr_en, 1'b0);
    check("t6_din", fifo_din, '0);
    check("t6_ch", fifo_ch, '0);
    check("t6_drop", drop_cnt, '0);
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    fifo_full = 1'b0;
    base = wr_ch_q.size();
    wait_writes(1, 10);
    if (wr_ch_q.size() > base) begin
      check("t6_regrant_ch", wr_ch_q[base], 3);
      check("t6_regrant_data", wr_data_q[base], 32'h0000_00E3);
    end
    settle();

    // Randomized traffic
    random_mode = 1'b1;
    repeat (2500) cycle();
    random_mode = 1'b0;
    full_left = 0;
    settle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
